counter_report_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/counter_report_tx.sv | 139 +++++++++++++
 tb/tb_counter_report_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART-path definitions: ASCII framing constants and the report FSM state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } report_state_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] bcd_digit);
    return ASCII_ZERO + {4'h0, bcd_digit};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, CNT_W steps in total.
// The first shift is folded into the load, so done pulses CNT_W-1 cycles after start.
module bin2bcd_seq #(
  parameter int CNT_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  import uart_pkg::*;

  localparam int CW = $clog2(CNT_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CNT_W - 1);

  logic [CNT_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj_s;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // add-3 correction for every digit that would overflow on the next shift
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // load / iterate / finish sequencing
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      bin_d  = bin << 1;
      bcd_d  = {{(4*DIGITS-1){1'b0}}, bin[CNT_W-1]};
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj_s, bin_q} << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/counter_report_tx.sv
// Renders a saturated counter snapshot as a fixed-width ASCII decimal frame and
// pushes it byte-by-byte into the UART TX FIFO; one request may queue behind the active frame.
module counter_report_tx #(
  parameter int CNT_W     = 14,
  parameter int DIGITS    = 4,
  parameter int MAX_VAL   = 9999,
  parameter int SEND_CRLF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] counter,
  input  logic             report_req,
  input  logic             tx_full,
  output logic             tx_push,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done
);
  import uart_pkg::*;

  localparam int FRAME_LEN = DIGITS + 2 * SEND_CRLF;
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] DIGIT_CNT = IDX_W'(DIGITS);
  localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(MAX_VAL);

  report_state_e       state_q, state_d;
  logic                pending_q, pending_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic                start_s;
  logic [CNT_W-1:0]    sat_s;
  logic                conv_busy_s, conv_done_s;
  logic [4*DIGITS-1:0] bcd_s, digit_shift_s;
  logic [7:0]          frame_byte_s;

  assign sat_s = (counter > SAT_VAL) ? SAT_VAL : counter;

  bin2bcd_seq #(
    .CNT_W  (CNT_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .bin   (sat_s),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .bcd   (bcd_s)
  );

  // state, pending flag and byte index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // next-state logic; a request arriving in DONE restarts directly, sampling counter on that edge
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    byte_idx_d = byte_idx_q;
    start_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (report_req && !conv_busy_s) begin
          state_d = ST_CONV;
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        pending_d = pending_q | report_req;
        if (conv_done_s) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_SEND: begin
        pending_d = pending_q | report_req;
        if (!tx_full) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            byte_idx_d = '0;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end else begin
          byte_idx_d = byte_idx_q;
        end
      end
      ST_DONE: begin
        if (pending_q || report_req) begin
          state_d   = ST_CONV;
          start_s   = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        pending_d  = 1'b0;
        byte_idx_d = '0;
      end
    endcase
  end

  // frame mux and handshake outputs; digit 0 of the frame is the most significant BCD nibble
  always_comb begin
    digit_shift_s = bcd_s << {byte_idx_q, 2'b00};
    if (byte_idx_q < DIGIT_CNT) begin
      frame_byte_s = ascii_digit(digit_shift_s[4*DIGITS-1 -: 4]);
    end else if (byte_idx_q == DIGIT_CNT) begin
      frame_byte_s = ASCII_CR;
    end else begin
      frame_byte_s = ASCII_LF;
    end

    if (state_q == ST_SEND) begin
      tx_push = !tx_full;
      tx_data = frame_byte_s;
    end else begin
      tx_push = 1'b0;
      tx_data = 8'h00;
    end
    busy = (state_q == ST_CONV) || (state_q == ST_SEND);
    done = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_counter_report_tx.sv
// Directed bench for counter_report_tx: frames, saturation, back-pressure, pending
// requests, reset abort, and a digits-only build.
module tb_counter_report_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        report_req = 1'b0;
  logic        report_req_b = 1'b0;
  logic        tx_full = 1'b0;
  logic [13:0] counter = 14'd0;
  logic        tx_push, busy, done;
  logic [7:0]  tx_data;
  logic        tx_push_b, busy_b, done_b;
  logic [7:0]  tx_data_b;

  counter_report_tx #(.CNT_W(14), .DIGITS(4), .MAX_VAL(9999), .SEND_CRLF(1)) dut (
    .clk(clk), .rst(rst), .counter(counter), .report_req(report_req), .tx_full(tx_full),
    .tx_push(tx_push), .tx_data(tx_data), .busy(busy), .done(done)
  );

  counter_report_tx #(.CNT_W(14), .DIGITS(4), .MAX_VAL(9999), .SEND_CRLF(0)) dut_b (
    .clk(clk), .rst(rst), .counter(counter), .report_req(report_req_b), .tx_full(tx_full),
    .tx_push(tx_push_b), .tx_data(tx_data_b), .busy(busy_b), .done(done_b)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cnt_b = 0;
  int         done_cyc = 0;
  logic       busy_at_done = 1'b0;
  logic [7:0] fifo[$];
  logic [7:0] fifo_b[$];
  int         push_cyc[$];

  // one clock cycle: record what the FIFO accepts at the coming edge, then move to the next negedge
  task automatic tick();
    #1;
    if (tx_push === 1'b1) begin
      fifo.push_back(tx_data);
      push_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      busy_at_done = busy;
      done_cyc = cyc;
    end
    if (tx_push_b === 1'b1) fifo_b.push_back(tx_data_b);
    if (done_b === 1'b1) done_cnt_b++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int start_cnt;
    start_cnt = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_cnt != start_cnt) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (tx_push !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: push=%b data=%h busy=%b done=%b, required 0 00 0 0",
               tx_push, tx_data, busy, done);
    end
    checks++;
    if (tx_push_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_b: push=%b busy=%b done=%b, required 0 0 0",
               tx_push_b, busy_b, done_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (fifo.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: pushes=%0d busy=%b, required 0 0", fifo.size(), busy);
    end
  endtask

  task automatic test_basic();
    int c0;
    bit seen;
    logic [47:0] exp_f;
    logic [7:0] got;
    exp_f = 48'h3030_3432_0D0A;
    fifo.delete(); push_cyc.delete(); done_cnt = 0;
    counter = 14'd42;
    c0 = cyc;
    pulse_req();
    checks++;
    if (busy !== 1'b1 || tx_push !== 1'b0) begin
      errors++;
      $display("FAIL basic_conv: busy=%b push=%b, required 1 0", busy, tx_push);
    end
    wait_done(40, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_done_timeout: done not seen, required within 40 cycles"); end
    checks++;
    if (fifo.size() != 6) begin errors++; $display("FAIL basic_len: got %0d bytes, required 6", fifo.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < fifo.size()) ? fifo[i] : 8'hxx;
      checks++;
      if (got !== exp_f[47-8*i -: 8]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h, required %h", i, got, exp_f[47-8*i -: 8]);
      end
    end
    checks++;
    if (push_cyc.size() != 6 || push_cyc[0] != c0 + 15 || push_cyc[5] != c0 + 20) begin
      errors++;
      $display("FAIL basic_timing: first/last push offset %0d/%0d, required 15/20",
               (push_cyc.size() > 0) ? push_cyc[0] - c0 : -1,
               (push_cyc.size() > 5) ? push_cyc[5] - c0 : -1);
    end
    checks++;
    if (done_cyc != c0 + 21 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_cycle: offset %0d busy=%b, required 21 0", done_cyc - c0, busy_at_done);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL basic_after: done pulses=%0d busy=%b data=%h, required 1 0 00", done_cnt, busy, tx_data);
    end
  endtask

  task automatic test_saturation();
    logic [13:0] vals [3];
    logic [47:0] exps [3];
    logic [7:0] got;
    bit seen;
    vals = '{14'd16383, 14'd0, 14'd10000};
    exps = '{48'h3939_3939_0D0A, 48'h3030_3030_0D0A, 48'h3939_3939_0D0A};
    for (int v = 0; v < 3; v++) begin
      fifo.delete();
      counter = vals[v];
      pulse_req();
      wait_done(40, seen);
      checks++;
      if (!seen || fifo.size() != 6) begin
        errors++;
        $display("FAIL sat_len_%0d: done=%b bytes=%0d, required 1 6", vals[v], seen, fifo.size());
      end
      for (int i = 0; i < 6; i++) begin
        got = (i < fifo.size()) ? fifo[i] : 8'hxx;
        checks++;
        if (got !== exps[v][47-8*i -: 8]) begin
          errors++;
          $display("FAIL sat_%0d_byte%0d: got %h, required %h", vals[v], i, got, exps[v][47-8*i -: 8]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] exp_f;
    logic [7:0] got;
    int n;
    bit seen;
    exp_f = 48'h3132_3334_0D0A;
    fifo.delete(); push_cyc.delete();
    counter = 14'd1234;
    pulse_req();
    n = 0;
    while (fifo.size() < 2 && n < 40) begin tick(); n++; end
    for (int s = 0; s < 3; s++) begin
      tx_full = 1'b1;
      #1;
      checks++;
      if (tx_push !== 1'b0 || tx_data !== 8'h33 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_cycle%0d: push=%b data=%h busy=%b, required 0 33 1", s, tx_push, tx_data, busy);
      end
      tick();
    end
    tx_full = 1'b0;
    wait_done(20, seen);
    checks++;
    if (!seen || fifo.size() != 6) begin
      errors++;
      $display("FAIL stall_len: done=%b bytes=%0d, required 1 6", seen, fifo.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < fifo.size()) ? fifo[i] : 8'hxx;
      checks++;
      if (got !== exp_f[47-8*i -: 8]) begin
        errors++;
        $display("FAIL stall_byte%0d: got %h, required %h", i, got, exp_f[47-8*i -: 8]);
      end
    end
    checks++;
    if (push_cyc.size() < 3 || push_cyc[2] != push_cyc[1] + 4) begin
      errors++;
      $display("FAIL stall_resume: gap %0d, required 4",
               (push_cyc.size() > 2) ? push_cyc[2] - push_cyc[1] : -1);
    end
  endtask

  task automatic test_pending();
    logic [95:0] exp_f;
    logic [7:0] got;
    int n;
    bit seen1, seen2;
    exp_f = 96'h3030_3035_0D0A_3030_3037_0D0A;
    fifo.delete(); done_cnt = 0;
    counter = 14'd5;
    pulse_req();
    n = 0;
    while (fifo.size() < 1 && n < 40) begin tick(); n++; end
    counter = 14'd6;
    pulse_req();
    tick();
    pulse_req();
    counter = 14'd7;
    wait_done(40, seen1);
    wait_done(40, seen2);
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (!seen1 || !seen2 || done_cnt != 2 || fifo.size() != 12) begin
      errors++;
      $display("FAIL pending_count: done pulses=%0d bytes=%0d, required 2 12", done_cnt, fifo.size());
    end
    for (int i = 0; i < 12; i++) begin
      got = (i < fifo.size()) ? fifo[i] : 8'hxx;
      checks++;
      if (got !== exp_f[95-8*i -: 8]) begin
        errors++;
        $display("FAIL pending_byte%0d: got %h, required %h", i, got, exp_f[95-8*i -: 8]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [47:0] exp_f;
    logic [7:0] got;
    int n;
    bit seen;
    exp_f = 48'h3032_3731_0D0A;
    fifo.delete(); done_cnt = 0;
    counter = 14'd314;
    pulse_req();
    tick();
    pulse_req();
    n = 0;
    while (fifo.size() < 2 && n < 40) begin tick(); n++; end
    checks++;
    if (fifo.size() != 2) begin errors++; $display("FAIL abort_reach_send: bytes=%0d, required 2", fifo.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (tx_push !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_outputs: push=%b busy=%b data=%h, required 0 0 00", tx_push, busy, tx_data);
    end
    fifo.delete();
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (fifo.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_pending_cleared: bytes=%0d done=%0d, required 0 0", fifo.size(), done_cnt);
    end
    counter = 14'd271;
    pulse_req();
    wait_done(40, seen);
    checks++;
    if (!seen || fifo.size() != 6) begin
      errors++;
      $display("FAIL abort_new_len: done=%b bytes=%0d, required 1 6", seen, fifo.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < fifo.size()) ? fifo[i] : 8'hxx;
      checks++;
      if (got !== exp_f[47-8*i -: 8]) begin
        errors++;
        $display("FAIL abort_new_byte%0d: got %h, required %h", i, got, exp_f[47-8*i -: 8]);
      end
    end
  endtask

  task automatic test_req_with_rst_and_no_crlf();
    logic [31:0] exp_f;
    logic [7:0] got;
    int n;
    fifo.delete(); done_cnt = 0;
    counter = 14'd99;
    rst = 1'b1;
    report_req = 1'b1;
    tick();
    rst = 1'b0;
    report_req = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (fifo.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_wins: bytes=%0d done=%0d busy=%b, required 0 0 0", fifo.size(), done_cnt, busy);
    end
    exp_f = 32'h3938_3736;
    fifo_b.delete(); done_cnt_b = 0;
    counter = 14'd9876;
    report_req_b = 1'b1;
    tick();
    report_req_b = 1'b0;
    n = 0;
    while (done_cnt_b == 0 && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done_cnt_b != 1 || fifo_b.size() != 4) begin
      errors++;
      $display("FAIL nocrlf_len: done=%0d bytes=%0d, required 1 4", done_cnt_b, fifo_b.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < fifo_b.size()) ? fifo_b[i] : 8'hxx;
      checks++;
      if (got !== exp_f[31-8*i -: 8]) begin
        errors++;
        $display("FAIL nocrlf_byte%0d: got %h, required %h", i, got, exp_f[31-8*i -: 8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_pending();
    test_reset_abort();
    test_req_with_rst_and_no_crlf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
